sec_down_timer: RTL and testbench
=================================

# sec_down_timer

Seconds countdown timer on the 6 MHz domain, the down-counting counterpart of the free-running seconds counter. It loads an 8-bit seconds value, decrements it once per second while running, and emits a single-cycle `done` pulse when the count reaches zero. It sits beside the seconds counter in the education/timer set, driving the same 7-seg/LED display path with a remaining-time value.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 6000000: clk_6m cycles per second, ≥2.
- `WIDTH`, default 8: counter width.

Ports (one clock; reset is synchronous and active-high):
- `clk_6m`  in  1  6 MHz clock, all logic on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `load`  in  1  load `load_val` into the count.
- `load_val`  in  WIDTH  seconds value to load.
- `start`  in  1  begin/resume countdown.
- `stop`  in  1  pause countdown.
- `Q`  out  WIDTH  remaining seconds, registered.
- `running`  out  1  countdown active, registered.
- `done`  out  1  one-cycle pulse on expiry, registered.

## Operation
- Prescaler `count`, range 1..TICKS_PER_SEC, advances only while `running`=1; `tick` = running && count==TICKS_PER_SEC, then count returns to 1.
- Reset: Q=0, running=0, done=0, count=1, reload register=0.
- Control priority per cycle: rst > load > stop > start.
- `load`: Q<=load_val, count<=1, reload register<=load_val. `running` unchanged, except when `start` is also high in the same cycle: running<=(load_val!=0).
- `load` while running with load_val=0: Q<=0, running<=0, no `done` pulse.
- `stop` (no load): running<=0; count held (not cleared), so resume continues the partial second.
- `start` (no load/stop): running<=1 if Q!=0; ignored when Q==0; no effect if already running.
- On tick: if Q>1, Q<=Q-1. If Q==1: Q<=0, done<=1 for exactly one cycle, running<=0 (see Configuration).
- `done`=0 in every cycle not following an expiry tick.
- Q never wraps below zero; decrement never occurs at Q==0 because running is never 1 with Q==0.
- Stop asserted in the same cycle as an expiry tick: stop wins; no decrement, no done, Q remains 1, count held at TICKS_PER_SEC (the next start expires on its first running cycle).

## Timing
- First decrement occurs TICKS_PER_SEC running cycles after start (count begins at 1, tick at TICKS_PER_SEC).
- Q, running and done update on the same edge as the tick; done high for the following cycle only.
- Load value N with start: done rises exactly N×TICKS_PER_SEC cycles after the load/start edge.
- Control inputs are sampled every edge; no handshake, no setup latency beyond one register.
- Reset mid-countdown: all outputs at reset values on the next edge; a pending done is dropped.

## Configuration
- Macro `SEC_DOWN_TIMER_AUTO_RELOAD_EN`.
- Defined: on expiry Q<=reload register value, running stays 1, done still pulses one cycle; timer repeats with period reload×TICKS_PER_SEC until stop/rst. Loading 0 still stops it.
- Undefined: expiry stops the timer (running<=0, Q=0); reload register omitted.

## Test plan
- TICKS_PER_SEC=4: rst, load 3 + start together -> Q 3→2→1→0 at cycles 4, 8, 12; done high only in cycle 12+1; running 0 afterwards.
- start with Q=0 after reset -> running stays 0, Q=0, done never asserts.
- Load 5, start, stop after 6 cycles (Q=4, count=3), wait 20, start -> Q=3 two cycles after resume; total expiry at 20 running cycles.
- Load 2 while running at Q=7 -> Q=2 next edge, count restarts, expiry 8 cycles later; load 0 while running -> running 0, no done.
- rst asserted on the expiry tick cycle -> Q=0, running=0, done=0 next edge.
- With SEC_DOWN_TIMER_AUTO_RELOAD_EN, load 2 + start -> done pulses every 8 cycles, Q cycles 2,1,2,1; without it -> single done then idle.

Source files
------------

// File: rtl/sec_down_timer.sv
// Seconds countdown timer: loads a seconds value, decrements once per
// TICKS_PER_SEC running cycles and pulses done on expiry.
// Optional feature: define SEC_DOWN_TIMER_AUTO_RELOAD_EN to restart from the
// last loaded value on every expiry instead of stopping.
module sec_down_timer #(
  parameter int unsigned TICKS_PER_SEC = 6000000,
  parameter int unsigned WIDTH         = 8
) (
  input  logic             clk_6m,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] Q,
  output logic             running,
  output logic             done
);

  localparam int unsigned    CW      = $clog2(TICKS_PER_SEC + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TICKS_PER_SEC);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] Q_ONE = WIDTH'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             tick;
`ifdef SEC_DOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign tick = (state_q == ST_RUN) && (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef SEC_DOWN_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      q_d   = load_val;
      cnt_d = CNT_ONE;
`ifdef SEC_DOWN_TIMER_AUTO_RELOAD_EN
      reload_d = load_val;
`endif
      // A zero load always halts; a non-zero load only changes run state with start.
      if (start || (load_val == '0))
        state_d = (load_val != '0) ? ST_RUN : ST_IDLE;
    end else if (stop) begin
      // Prescaler is held so a later start resumes the partial second.
      state_d = ST_IDLE;
    end else if (state_q == ST_RUN) begin
      cnt_d = tick ? CNT_ONE : cnt_q + CNT_ONE;
      if (tick) begin
        if (q_q > Q_ONE) begin
          q_d = q_q - Q_ONE;
        end else begin
          done_d = 1'b1;
`ifdef SEC_DOWN_TIMER_AUTO_RELOAD_EN
          q_d     = reload_q;
          state_d = (reload_q != '0) ? ST_RUN : ST_IDLE;
`else
          q_d     = '0;
          state_d = ST_IDLE;
`endif
        end
      end
    end else if (start && (q_q != '0)) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk_6m) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= CNT_ONE;
      done_q  <= 1'b0;
`ifdef SEC_DOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef SEC_DOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign Q       = q_q;
  assign running = (state_q == ST_RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_sec_down_timer.sv
// Directed bench for sec_down_timer with TICKS_PER_SEC=4; expectations follow
// SEC_DOWN_TIMER_AUTO_RELOAD_EN when it is defined.
module tb_sec_down_timer;

`ifdef SEC_DOWN_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk_6m = 1'b0;
  logic       rst, load, start, stop;
  logic [7:0] load_val;
  logic [7:0] Q;
  logic       running, done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  sec_down_timer #(
    .TICKS_PER_SEC(4),
    .WIDTH        (8)
  ) dut (
    .clk_6m  (clk_6m),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .start   (start),
    .stop    (stop),
    .Q       (Q),
    .running (running),
    .done    (done)
  );

  always #5 clk_6m = ~clk_6m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] eq, input bit er, input bit ed);
    check({tag, ".Q"}, 32'(Q), 32'(eq));
    check({tag, ".running"}, 32'(running), 32'(er));
    check({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk_6m);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; load_val = '0;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned pulses;

    // Reset state and basic countdown: load 3 + start.
    do_reset();
    chk_outs("reset", 8'd0, 1'b0, 1'b0);
    load = 1'b1; start = 1'b1; load_val = 8'd3;
    cyc(1);
    load = 1'b0; start = 1'b0;
    chk_outs("t1_loaded", 8'd3, 1'b1, 1'b0);
    cyc(3);
    chk_outs("t1_c3", 8'd3, 1'b1, 1'b0);
    cyc(1);
    chk_outs("t1_c4", 8'd2, 1'b1, 1'b0);
    cyc(4);
    chk_outs("t1_c8", 8'd1, 1'b1, 1'b0);
    cyc(3);
    chk_outs("t1_c11", 8'd1, 1'b1, 1'b0);
    cyc(1);
    chk_outs("t1_expire", AUTO ? 8'd3 : 8'd0, AUTO, 1'b1);
    cyc(1);
    check("t1_done_drop", 32'(done), 32'(0));

    // Start with Q==0 is ignored.
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk_outs("t2_start_zero", 8'd0, 1'b0, 1'b0);
    end
    start = 1'b0;

    // Stop/resume keeps the partial second.
    do_reset();
    load = 1'b1; load_val = 8'd5;
    cyc(1);
    load = 1'b0;
    chk_outs("t3_load_only", 8'd5, 1'b0, 1'b0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_outs("t3_start", 8'd5, 1'b1, 1'b0);
    cyc(6);
    chk_outs("t3_pre_stop", 8'd4, 1'b1, 1'b0);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk_outs("t3_stopped", 8'd4, 1'b0, 1'b0);
    cyc(20);
    chk_outs("t3_paused", 8'd4, 1'b0, 1'b0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_outs("t3_resume", 8'd4, 1'b1, 1'b0);
    cyc(1);
    check("t3_r1.Q", 32'(Q), 32'(4));
    cyc(1);
    check("t3_r2.Q", 32'(Q), 32'(3));
    cyc(11);
    chk_outs("t3_r13", 8'd1, 1'b1, 1'b0);
    cyc(1);
    chk_outs("t3_expire", AUTO ? 8'd5 : 8'd0, AUTO, 1'b1);

    // Reload while running restarts the prescaler.
    do_reset();
    load = 1'b1; start = 1'b1; load_val = 8'd7;
    cyc(1);
    start = 1'b0; load = 1'b0;
    cyc(2);
    load = 1'b1; load_val = 8'd2;
    cyc(1);
    load = 1'b0;
    chk_outs("t4_reload", 8'd2, 1'b1, 1'b0);
    cyc(7);
    chk_outs("t4_c7", 8'd1, 1'b1, 1'b0);
    cyc(1);
    chk_outs("t4_expire", AUTO ? 8'd2 : 8'd0, AUTO, 1'b1);

    // Load 0 while running halts without done.
    do_reset();
    load = 1'b1; start = 1'b1; load_val = 8'd9;
    cyc(1);
    start = 1'b0; load = 1'b0;
    cyc(2);
    load = 1'b1; load_val = 8'd0;
    cyc(1);
    load = 1'b0;
    chk_outs("t5_load0", 8'd0, 1'b0, 1'b0);
    cyc(1);
    chk_outs("t5_load0_after", 8'd0, 1'b0, 1'b0);

    // Reset on the expiry tick drops the pending done.
    do_reset();
    load = 1'b1; start = 1'b1; load_val = 8'd1;
    cyc(1);
    load = 1'b0; start = 1'b0;
    cyc(3);
    chk_outs("t6_pre", 8'd1, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_outs("t6_rst", 8'd0, 1'b0, 1'b0);
    cyc(1);
    chk_outs("t6_after", 8'd0, 1'b0, 1'b0);

    // Stop on the expiry tick wins; next start expires immediately.
    load = 1'b1; start = 1'b1; load_val = 8'd1;
    cyc(1);
    load = 1'b0; start = 1'b0;
    cyc(3);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk_outs("t7_stop_tick", 8'd1, 1'b0, 1'b0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_outs("t7_resume", 8'd1, 1'b1, 1'b0);
    cyc(1);
    chk_outs("t7_expire", AUTO ? 8'd1 : 8'd0, AUTO, 1'b1);

    // Repeat behaviour over 24 cycles: auto-reload pulses every 8.
    do_reset();
    load = 1'b1; start = 1'b1; load_val = 8'd2;
    cyc(1);
    load = 1'b0; start = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 24; i++) begin
      cyc(1);
      if (done) pulses++;
      if (i == 20) check("t8_q20", 32'(Q), AUTO ? 32'(1) : 32'(0));
    end
    check("t8_pulses", 32'(pulses), AUTO ? 32'(3) : 32'(1));
    check("t8_running", 32'(running), 32'(AUTO));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
